// File: rtl/lfp_pkg.sv
// Shared types and helpers for the serial logarithmic (Mitchell) floating-point multiplier.
package lfp_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } lfp_state_e;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } lfp_cls_e;

  localparam int FLAGS_W   = 4;
  localparam int FLAG_NAN  = 3;
  localparam int FLAG_INF  = 2;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_UNF  = 0;
  localparam int EXP_MAX_W = 16;

  // Subnormals (exp == 0) classify as zero so the datapath flushes them.
  function automatic lfp_cls_e lfp_classify(input int exp_w,
                                            input logic [EXP_MAX_W-1:0] exp_f,
                                            input logic man_nz);
    logic [EXP_MAX_W-1:0] ones;
    lfp_cls_e cls;
    ones = (EXP_MAX_W'(1) << exp_w) - EXP_MAX_W'(1);
    cls  = CLS_NORM;
    if (exp_f == '0)
      cls = CLS_ZERO;
    else if (exp_f == ones)
      cls = man_nz ? CLS_NAN : CLS_INF;
    return cls;
  endfunction

endpackage

// File: rtl/lfp_mitchell_core.sv
// Combinational Mitchell-approximate multiply of two packed floating-point words,
// including special-value resolution and exponent saturation.
module lfp_mitchell_core
  import lfp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [EXP_W+MAN_W:0] i_a,
  input  logic [EXP_W+MAN_W:0] i_b,
  output logic [EXP_W+MAN_W:0] o_res,
  output logic [FLAGS_W-1:0]   o_flags
);

  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO_S = '0;

  logic               w_sa, w_sb, w_s;
  logic [EXP_W-1:0]   w_ea, w_eb;
  logic [MAN_W-1:0]   w_ma, w_mb;
  logic [MAN_W:0]     w_msum;
  logic signed [EW-1:0] w_e;
  lfp_cls_e           w_ca, w_cb;
  logic               w_any_nan, w_any_inf, w_any_zero;
  logic [1:0]         w_sat;

  function automatic logic [EXP_W+MAN_W:0] pack_inf(input logic s);
    return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [EXP_W+MAN_W:0] pack_zero(input logic s);
    return {s, {(EXP_W+MAN_W){1'b0}}};
  endfunction

  // Returns {overflow, underflow} for the unbiased-sum exponent.
  function automatic logic [1:0] sat_exp(input logic signed [EW-1:0] e);
    return {e >= EMAX_S, e <= EZERO_S};
  endfunction

  assign {w_sa, w_ea, w_ma} = i_a;
  assign {w_sb, w_eb, w_mb} = i_b;
  assign w_s    = w_sa ^ w_sb;
  // Log-domain add: fraction carry bumps the exponent, fraction itself is kept as-is.
  assign w_msum = {1'b0, w_ma} + {1'b0, w_mb};
  assign w_e    = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS_S
                + $signed({{(EW-1){1'b0}}, w_msum[MAN_W]});
  assign w_sat  = sat_exp(w_e);

  assign w_ca = lfp_classify(EXP_W, EXP_MAX_W'(w_ea), |w_ma);
  assign w_cb = lfp_classify(EXP_W, EXP_MAX_W'(w_eb), |w_mb);
  assign w_any_nan  = (w_ca == CLS_NAN)  || (w_cb == CLS_NAN);
  assign w_any_inf  = (w_ca == CLS_INF)  || (w_cb == CLS_INF);
  assign w_any_zero = (w_ca == CLS_ZERO) || (w_cb == CLS_ZERO);

  always_comb begin
    o_res   = {w_s, w_e[EXP_W-1:0], w_msum[MAN_W-1:0]};
    o_flags = '0;
    if (w_any_nan || (w_any_inf && w_any_zero)) begin
      o_res             = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      o_flags[FLAG_NAN] = 1'b1;
    end else if (w_any_inf) begin
      o_res             = pack_inf(w_s);
      o_flags[FLAG_INF] = 1'b1;
    end else if (w_any_zero) begin
      o_res             = pack_zero(w_s);
    end else if (w_sat[1]) begin
      o_res             = pack_inf(w_s);
      o_flags[FLAG_OVF] = 1'b1;
    end else if (w_sat[0]) begin
      o_res             = pack_zero(w_s);
      o_flags[FLAG_UNF] = 1'b1;
    end
  end

endmodule

// File: rtl/lfp_mul_serial.sv
// Beat-serial Mitchell floating-point multiplier: LOAD operands, one CALC cycle,
// then SEND the registered product under a valid/ready handshake.
module lfp_mul_serial
  import lfp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BUS_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BUS_W-1:0]   a_in,
  input  logic [BUS_W-1:0]   b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BUS_W-1:0]   out_data,
  output logic [FLAGS_W-1:0] out_flags
);

  localparam int WORD_W = 1 + EXP_W + MAN_W;
  localparam int BEATS  = (WORD_W + BUS_W - 1) / BUS_W;
  localparam int PAD_W  = BEATS * BUS_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  lfp_state_e          r_state, w_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [PAD_W-1:0]    r_a_sh, r_b_sh;
  logic [WORD_W-1:0]   w_res_p0, r_res_p1;
  logic [FLAGS_W-1:0]  w_flags_p0, r_flags_p1;
  logic [PAD_W-1:0]    w_res_pad;
  logic                w_in_ready, w_out_valid, w_acc;
  logic                w_unused_pad;

  assign in_ready  = w_in_ready & ~rst;
  assign out_valid = w_out_valid & ~rst;
  assign w_acc     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_n     = r_cnt;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      LOAD: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          if (r_cnt == LAST) begin
            w_cnt_n = '0;
            w_next  = CALC;
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
      end
      CALC: w_next = SEND;
      SEND: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          if (r_cnt == LAST) begin
            w_cnt_n = '0;
            w_next  = LOAD;
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_next  = LOAD;
        w_cnt_n = '0;
      end
    endcase
  end

  // p0: operand assembly; beats enter at the top so beat 0 ends at bit 0.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_a_sh <= PAD_W'({a_in, r_a_sh} >> BUS_W);
      r_b_sh <= PAD_W'({b_in, r_b_sh} >> BUS_W);
    end
  end

  lfp_mitchell_core #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_core (
    .i_a     (r_a_sh[WORD_W-1:0]),
    .i_b     (r_b_sh[WORD_W-1:0]),
    .o_res   (w_res_p0),
    .o_flags (w_flags_p0)
  );

  // p1: result register, loaded once in CALC and held through SEND.
  always_ff @(posedge clk) begin
    if (r_state == CALC) begin
      r_res_p1   <= w_res_p0;
      r_flags_p1 <= w_flags_p0;
    end
  end

  assign w_res_pad    = PAD_W'(r_res_p1);
  assign w_unused_pad = ^{r_a_sh, r_b_sh};

  always_comb begin
    out_data  = '0;
    out_flags = '0;
    if (out_valid) begin
      out_data  = w_res_pad[int'(r_cnt)*BUS_W +: BUS_W];
      out_flags = r_flags_p1;
    end
  end

endmodule

// File: doc/lfp_mul_serial.md
# lfp_mul_serial

Parametrised successor to the byte-serial logarithmic (Mitchell) floating-point multiplier used as the TinyTapeout user macro. It accepts two IEEE-style operands of generic exponent/mantissa width over narrow serial buses, computes the Mitchell-approximate product with full special-value handling, and returns the result serially under a valid/ready handshake. It sits behind the pad wrapper, which maps `ui_in`/`uio_in`/`uo_out` onto its buses.

## Interface
- `EXP_W`, 5: exponent field width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, 10: mantissa field width; WORD_W = 1+EXP_W+MAN_W.
- `BUS_W`, 8: serial beat width; BEATS = ceil(WORD_W/BUS_W).

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  A/B beat present.
- `in_ready`  out  1  block accepts a beat.
- `a_in`  in  BUS_W  operand A beat, least-significant beat first.
- `b_in`  in  BUS_W  operand B beat, same order.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer takes beat.
- `out_data`  out  BUS_W  result beat, least-significant first.
- `out_flags`  out  4  {nan, inf, ovf, unf}, stable across all beats of one result.

## Operation
- FSM states: LOAD (reset state), CALC, SEND.
- LOAD: `in_ready`=1. A beat transfers when `in_valid & in_ready`; beat counter increments. Upon transfer of beat BEATS-1, go to CALC; counter clears.
- Operand bits above WORD_W in the last beat are ignored.
- CALC (exactly one cycle, `in_ready`=0): register result word and flags; go to SEND.
- SEND: `out_valid`=1, `out_data` = beat[cnt] of result; unused high bits of last beat driven 0. Beat transfers on `out_valid & out_ready`. After transfer of beat BEATS-1, go to LOAD.
- Arithmetic (normals): s = sa^sb; e = ea+eb-bias+c; {c, m} = ma+mb (MAN_W+1-bit sum, carry c, fraction m kept unrounded). Intermediate e held in EXP_W+2 signed bits.
- Input exp=0 (zero/subnormal) is treated as zero (flush).
- Priority:
  - Any NaN input, or inf×zero: result = canonical qNaN (s=0, exp all-ones, mantissa MSB=1); nan=1.
  - Else any inf: result = signed inf; inf=1.
  - Else any zero: result = signed zero, no flag.
  - Else e ≥ all-ones: result = signed inf; ovf=1.
  - Else e ≤ 0: result = signed zero; unf=1.
  - Otherwise normal.
- `rst` asserted in any state: return to LOAD, discard partial operands and pending result, clear counter.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_flags`=0, `in_ready`=0 while `rst`=1; 1 in the first cycle after release.
- Latency: last input beat accepted at edge k. CALC occupies cycle k→k+1. First result beat is valid after edge k+1.
- Throughput: one product per 2·BEATS+1 cycles with no backpressure.
- `out_data`/`out_flags` are held while `out_valid & ~out_ready`.
- `in_valid` is ignored outside LOAD. Gaps in `in_valid` within a word only stall; partial beats are retained.

## Structure
- Package `lfp_pkg`:
  - state enum (LOAD/CALC/SEND);
  - flag bit indices;
  - class-decode function (zero/inf/nan/normal) parametrised by EXP_W/MAN_W.
- Sub-module `lfp_mitchell_core`: purely combinational operand→{result, flags}. The top holds shift registers, counter, FSM, and output register.

## Test plan
- Default params. A=0x3E00 (1.5), B=0x4200 (3.0), beats 0x00/0x3E and 0x00/0x42 → beats 0x00, 0x44 (0x4400 = 4.0, Mitchell), flags 0; first beat valid 2 cycles after the last input beat.
- 0x4000×0x4200 → 0x4600 (exact 6.0). 0x3C00×0xBC00 → 0xBC00.
- 0x7BFF×0x7BFF → 0x7C00, ovf=1. 0x0400×0x0400 → 0x0000, unf=1. 0x7C00×0x0000 → 0x7E00, nan=1. 0x0001×0x3C00 → 0x0000, flags 0.
- Backpressure: `out_ready` low for 5 cycles in SEND → beat 0 held stable and `in_ready`=0 throughout, then the sequence completes correctly. An `in_valid` gap between beats yields the same result.
- `rst` pulse after 1 input beat, then a fresh 0x3C00×0x3C00 → 0x3C00 (no stale beat). `rst` during SEND → `out_valid` 0 the next cycle.
- EXP_W=8, MAN_W=23, BUS_W=8 (4 beats): 0x3FC00000×0x40400000 → 0x40800000 (4.0); 0x3F800000×0x3F800000 → 0x3F800000.
